// File: rtl/spi_arbiter.sv
// spi_arbiter: shares one SPI master between four requesters.
// Picks a winner (round robin by default), runs one byte transaction on
// the master with a watchdog, and returns the received byte with a
// one-cycle acknowledge to the winner.
// Optional build macro: SPI_ARB_FIXED_PRIO_EN selects fixed priority
// (requester 0 highest) instead of round robin.
module spi_arbiter #(
   parameter int TIMEOUT = 40
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  req,
   input  logic [31:0] req_data,
   output logic [3:0]  ack,
   output logic [7:0]  rsp_data,
   output logic        timeout_err,
   output logic        m_start,
   output logic [7:0]  m_din,
   input  logic        m_done,
   input  logic [7:0]  m_dout,
   output logic [3:0]  cs_n
);

   // Last counter value of the WAIT window before the watchdog fires.
   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARB,
      S_START,
      S_WAIT,
      S_DONE
   } state_t;

   state_t      r_state;
   logic [1:0]  r_sel;
   logic [7:0]  r_cnt;
`ifndef SPI_ARB_FIXED_PRIO_EN
   logic [1:0]  r_ptr;
`endif

   logic [1:0]  w_base;
   logic [3:0]  w_rot;
   logic [1:0]  w_off;
   logic [1:0]  w_win;
   logic        w_any;
   logic [7:0]  w_win_byte;
   logic [7:0]  w_bytes [4];
   logic [3:0]  w_win_hot;
   logic [3:0]  w_sel_hot;

   // Search origin: fixed priority always starts at requester 0.
`ifdef SPI_ARB_FIXED_PRIO_EN
   assign w_base = 2'd0;
`else
   assign w_base = r_ptr;
`endif

   // Rotate the request vector so bit 0 is the first candidate, and split
   // the packed tx bytes into one lane per requester.
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         assign w_rot[gi]     = req[w_base + 2'(gi)];
         assign w_bytes[gi]   = req_data[8*gi +: 8];
         assign w_win_hot[gi] = (w_win == 2'(gi));
         assign w_sel_hot[gi] = (r_sel == 2'(gi));
      end
   endgenerate

   // Priority encode the rotated vector: lowest offset from the origin wins.
   always_comb begin
      w_off = 2'd0;
      if (w_rot[0])      w_off = 2'd0;
      else if (w_rot[1]) w_off = 2'd1;
      else if (w_rot[2]) w_off = 2'd2;
      else               w_off = 2'd3;
   end

   assign w_any      = |req;
   assign w_win      = w_base + w_off;
   assign w_win_byte = w_bytes[w_win];

   // Transaction sequencer: all outputs are registered here.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state     <= S_IDLE;
         r_sel       <= 2'd0;
         r_cnt       <= 8'd0;
`ifndef SPI_ARB_FIXED_PRIO_EN
         r_ptr       <= 2'd0;
`endif
         ack         <= 4'h0;
         rsp_data    <= 8'h00;
         timeout_err <= 1'b0;
         m_start     <= 1'b0;
         m_din       <= 8'h00;
         cs_n        <= 4'hF;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_any) r_state <= S_ARB;
            end
            S_ARB: begin
               // Requests may have vanished since IDLE; fall back if so.
               if (w_any) begin
                  r_sel   <= w_win;
                  m_din   <= w_win_byte;
`ifndef SPI_ARB_FIXED_PRIO_EN
                  r_ptr   <= w_win + 2'd1;
`endif
                  m_start <= 1'b1;
                  cs_n    <= ~w_win_hot;
                  r_state <= S_START;
               end else begin
                  r_state <= S_IDLE;
               end
            end
            S_START: begin
               m_start <= 1'b0;
               r_cnt   <= 8'd0;
               r_state <= S_WAIT;
            end
            S_WAIT: begin
               r_cnt <= r_cnt + 8'd1;
               // Completion beats the watchdog when both land together.
               if (m_done) begin
                  rsp_data    <= m_dout;
                  timeout_err <= 1'b0;
                  ack         <= w_sel_hot;
                  cs_n        <= 4'hF;
                  r_state     <= S_DONE;
               end else if (r_cnt == CNT_LAST) begin
                  rsp_data    <= 8'h00;
                  timeout_err <= 1'b1;
                  ack         <= w_sel_hot;
                  cs_n        <= 4'hF;
                  r_state     <= S_DONE;
               end
            end
            S_DONE: begin
               ack         <= 4'h0;
               timeout_err <= 1'b0;
               r_state     <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_spi_arbiter.sv
// Bench for spi_arbiter: a transaction-timeline model predicts every output
// each cycle; directed tests add literal expectations on top.
module tb_spi_arbiter;

   localparam int TO = 40;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [3:0]  req = 4'h0;
   logic [31:0] req_data = 32'h0;
   logic [3:0]  ack;
   logic [7:0]  rsp_data;
   logic        timeout_err;
   logic        m_start;
   logic [7:0]  m_din;
   logic        m_done = 1'b0;
   logic [7:0]  m_dout = 8'hC3;
   logic [3:0]  cs_n;

   int n_checks = 0;
   int n_err    = 0;

   spi_arbiter #(.TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset), .req(req), .req_data(req_data),
      .ack(ack), .rsp_data(rsp_data), .timeout_err(timeout_err),
      .m_start(m_start), .m_din(m_din), .m_done(m_done), .m_dout(m_dout),
      .cs_n(cs_n)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ---------------- timeline model ----------------
   // slot s = interval following posedge number s
   int         e = 0;
   bit         busy = 0;
   int         t_arb = 0, t_start = -1, t_done = -1, free_edge = 0;
   int         m_pb, m_idx;
   bit         m_found;
   logic [1:0] msel = 0, mptr = 0;
   logic [7:0] x_din = 0, x_rsp = 0;
   logic       x_terr_v = 0;
   logic [3:0] x_ack = 0, x_cs = 4'hF;
   logic       x_mstart = 0, x_terr = 0;
   bit         x_chk_din = 0, x_chk_rsp = 0;

   always @(posedge clk) begin
      e = e + 1;
      x_chk_din = 0;
      x_chk_rsp = 0;
      if (!reset) begin
         busy = 0; mptr = 0; free_edge = e + 1;
         x_din = 0; x_rsp = 0; t_start = -1; t_done = -1;
         x_chk_din = 1; x_chk_rsp = 1;
      end else begin
         if (busy && t_done >= 0 && e == t_done + 1) begin
            busy = 0; free_edge = e + 1;
         end
         if (!busy) begin
            if (e >= free_edge && req != 4'h0) begin
               busy = 1; t_arb = e; t_start = -1; t_done = -1;
            end
         end else if (t_start < 0) begin
            if (e == t_arb + 1) begin
`ifdef SPI_ARB_FIXED_PRIO_EN
               m_pb = 0;
`else
               m_pb = int'(mptr);
`endif
               m_found = 0;
               for (int k = 0; k < 4; k++) begin
                  m_idx = (m_pb + k) % 4;
                  if (!m_found && req[m_idx]) begin
                     m_found = 1;
                     msel = 2'(m_idx);
                  end
               end
               if (m_found) begin
                  x_din = req_data[8*int'(msel) +: 8];
                  mptr = msel + 2'd1;
                  t_start = e;
               end else begin
                  busy = 0; free_edge = e + 1;
               end
            end
         end else if (t_done < 0 && e >= t_start + 2) begin
            if (m_done) begin
               t_done = e; x_rsp = m_dout; x_terr_v = 0;
            end else if (e == t_start + TO + 1) begin
               t_done = e; x_rsp = 8'h00; x_terr_v = 1;
            end
         end
      end
      x_mstart = busy && t_start >= 0 && t_start == e;
      x_cs = 4'hF;
      if (busy && t_start >= 0 && e >= t_start && t_done < 0) x_cs[msel] = 1'b0;
      x_ack  = (busy && t_done == e) ? (4'b0001 << msel) : 4'h0;
      x_terr = (busy && t_done == e) ? x_terr_v : 1'b0;
      if (busy && t_start >= 0) x_chk_din = 1;
      if (x_ack != 4'h0) x_chk_rsp = 1;
   end

   // Per-cycle comparison against the model
   always @(negedge clk) begin
      if (e > 0) begin
         chk("ack", 32'(ack), 32'(x_ack));
         chk("cs_n", 32'(cs_n), 32'(x_cs));
         chk("m_start", 32'(m_start), 32'(x_mstart));
         chk("timeout_err", 32'(timeout_err), 32'(x_terr));
         if (x_chk_din) chk("m_din", 32'(m_din), 32'(x_din));
         if (x_chk_rsp) chk("rsp_data", 32'(rsp_data), 32'(x_rsp));
      end
   end

   // ---------------- SPI master stand-in ----------------
   int         mst_delay = 0;   // 0: never completes
   logic [7:0] mst_byte  = 8'h00;
   bit         mst_early = 0;
   bit         mst_kill  = 0;
   int         mst_cnt   = 0;

   always @(negedge clk) begin
      m_done = 1'b0;
      if (mst_kill) begin
         mst_cnt = 0;
      end else begin
         if (mst_cnt > 0) begin
            mst_cnt = mst_cnt - 1;
            if (mst_cnt == 0) begin
               m_done = 1'b1;
               m_dout = mst_byte;
            end
         end
         if (m_start) begin
            if (mst_early) begin
               m_done = 1'b1;
               m_dout = 8'hEE;
            end
            if (mst_delay > 0) mst_cnt = mst_delay;
         end
      end
   end

   // START-slot recorder
   int         start_slot = 0;
   int         start_cnt  = 0;
   logic [7:0] start_din  = 0;
   always @(negedge clk) begin
      if (m_start) begin
         start_slot = e;
         start_din  = m_din;
         start_cnt  = start_cnt + 1;
      end
   end

   // ---------------- directed tests ----------------
   task automatic wait_ack(input int budget);
      bit got = 0;
      for (int i = 0; i < budget && !got; i++) begin
         @(negedge clk);
         if (ack != 4'h0) got = 1;
      end
      n_checks++;
      if (!got) begin
         n_err++;
         $display("FAIL ack_wait: got no ack expected ack within %0d cycles", budget);
      end
   endtask

   task automatic wait_start(input int budget);
      bit got = 0;
      for (int i = 0; i < budget && !got; i++) begin
         @(negedge clk);
         if (m_start) got = 1;
      end
      n_checks++;
      if (!got) begin
         n_err++;
         $display("FAIL start_wait: got no m_start expected within %0d cycles", budget);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      mst_kill = 1;
      reset = 1'b0;
      req = 4'h0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      mst_kill = 0;
   endtask

   function automatic int hot2idx(input logic [3:0] h);
      for (int i = 0; i < 4; i++) if (h[i]) return i;
      return -1;
   endfunction

   task automatic txn(input logic [3:0] r, input logic [31:0] d, input int dly,
                      input logic [7:0] b, input bit early,
                      output logic [3:0] a_ack, output logic [7:0] a_rsp,
                      output logic a_terr, output logic [3:0] a_cs, output int a_lat);
      mst_delay = dly; mst_byte = b; mst_early = early; mst_kill = 0;
      start_cnt = 0;
      @(negedge clk);
      req = r; req_data = d;
      wait_ack(TO + 20);
      a_ack = ack; a_rsp = rsp_data; a_terr = timeout_err; a_cs = cs_n;
      a_lat = e - start_slot;
      req = 4'h0;
      $display("txn req=%b ack=%b din=%h rsp=%h terr=%b lat=%0d", r, a_ack, start_din, a_rsp, a_terr, a_lat);
   endtask

   logic [3:0] a_ack, a_cs;
   logic [7:0] a_rsp;
   logic       a_terr;
   int         a_lat;
   int         order [5];
   int         exp_order [5];

   initial begin
      repeat (3) @(negedge clk);
      chk("reset_cs_n", 32'(cs_n), 32'hF);
      chk("reset_ack", 32'(ack), 32'h0);
      chk("reset_m_din", 32'(m_din), 32'h0);
      reset = 1'b1;

      // Single request
      txn(4'b0100, 32'h00A5_0000, 16, 8'h3C, 0, a_ack, a_rsp, a_terr, a_cs, a_lat);
      chk("single_ack", 32'(a_ack), 32'h4);
      chk("single_rsp", 32'(a_rsp), 32'h3C);
      chk("single_terr", 32'(a_terr), 32'h0);
      chk("single_din", 32'(start_din), 32'hA5);
      chk("single_lat", 32'(a_lat), 32'd17);
      chk("single_nstart", 32'(start_cnt), 32'd1);

      // Fairness with all requests held
      do_reset();
      mst_delay = 2; mst_byte = 8'h11; mst_early = 0;
`ifdef SPI_ARB_FIXED_PRIO_EN
      exp_order = '{0, 0, 0, 0, 0};
`else
      exp_order = '{0, 1, 2, 3, 0};
`endif
      @(negedge clk);
      req = 4'b1111; req_data = 32'h4433_2211;
      for (int i = 0; i < 5; i++) begin
         wait_ack(30);
         order[i] = hot2idx(ack);
         $display("txn fair ack=%b rsp=%h", ack, rsp_data);
      end
      req = 4'h0;
      for (int i = 0; i < 5; i++) chk($sformatf("fair_grant%0d", i), 32'(order[i]), 32'(exp_order[i]));

      // Watchdog timeout
      txn(4'b0001, 32'h0000_0099, 0, 8'h00, 0, a_ack, a_rsp, a_terr, a_cs, a_lat);
      chk("to_ack", 32'(a_ack), 32'h1);
      chk("to_terr", 32'(a_terr), 32'h1);
      chk("to_rsp", 32'(a_rsp), 32'h00);
      chk("to_cs_n", 32'(a_cs), 32'hF);
      chk("to_lat", 32'(a_lat), 32'd41);

      // Completion on the watchdog's last cycle
      txn(4'b1000, 32'h7700_0000, TO, 8'h5A, 0, a_ack, a_rsp, a_terr, a_cs, a_lat);
      chk("coll_terr", 32'(a_terr), 32'h0);
      chk("coll_rsp", 32'(a_rsp), 32'h5A);
      chk("coll_lat", 32'(a_lat), 32'd41);

      // m_done during START is ignored
      txn(4'b0100, 32'h0042_0000, 5, 8'h77, 1, a_ack, a_rsp, a_terr, a_cs, a_lat);
      chk("early_rsp", 32'(a_rsp), 32'h77);
      chk("early_lat", 32'(a_lat), 32'd6);

      // Request withdrawn in the START cycle
      mst_delay = 4; mst_byte = 8'hB2; mst_early = 0;
      @(negedge clk);
      req = 4'b0010; req_data = 32'h0000_D100;
      wait_start(10);
      req = 4'h0;
      req_data = 32'hFFFF_FFFF;
      wait_ack(20);
      chk("wd_ack", 32'(ack), 32'h2);
      chk("wd_rsp", 32'(rsp_data), 32'hB2);
      chk("wd_din", 32'(m_din), 32'hD1);
      $display("txn withdraw ack=%b rsp=%h", ack, rsp_data);

      // Reset in the middle of WAIT
      mst_delay = 30; mst_byte = 8'h66;
      @(negedge clk);
      req = 4'b0010; req_data = 32'h0000_2200;
      wait_start(10);
      repeat (5) @(negedge clk);
      mst_kill = 1;
      reset = 1'b0;
      req = 4'h0;
      @(negedge clk);
      chk("mrst_cs_n", 32'(cs_n), 32'hF);
      chk("mrst_ack", 32'(ack), 32'h0);
      reset = 1'b1;
      $display("txn reset-abort cs_n=%b ack=%b", cs_n, ack);
      txn(4'b1010, 32'hAB00_CD00, 3, 8'h31, 0, a_ack, a_rsp, a_terr, a_cs, a_lat);
      chk("mrst_grant_ptr0", 32'(a_ack), 32'h2);
      txn(4'b1000, 32'h8800_0000, 3, 8'h32, 0, a_ack, a_rsp, a_terr, a_cs, a_lat);
      chk("mrst_grant3", 32'(a_ack), 32'h8);
      chk("mrst_din3", 32'(start_din), 32'h88);
      txn(4'b1001, 32'h9900_0011, 3, 8'h33, 0, a_ack, a_rsp, a_terr, a_cs, a_lat);
      chk("mrst_wrap0", 32'(a_ack), 32'h1);

      repeat (5) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

   // Absolute time limit
   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish expected end before limit");
      $fatal(1, "time limit");
   end

endmodule

// File: doc/spi_arbiter.md
# spi_arbiter

Round-robin arbiter and transaction sequencer that shares one SPI master between four requesters. It sits between the requesters and the SPI master:
- latches the winning requester's byte;
- drives the master's start/data inputs and the per-slave chip selects;
- waits for the master's completion, with a watchdog;
- returns the received byte to the winner with a one-cycle acknowledge.

## Interface
Parameters:
- TIMEOUT, default 40: maximum WAIT cycles before the transaction is aborted; legal range 2..255.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-low reset.
- req  in  4  request per requester; held high until its ack.
- req_data  in  32  packed tx bytes; requester i at [8i+7:8i].
- ack  out  4  one-cycle completion pulse to the granted requester.
- rsp_data  out  8  received byte; valid only while any ack bit is high.
- timeout_err  out  1  high together with ack when the watchdog aborted the transaction.
- m_start  out  1  one-cycle start pulse to the SPI master.
- m_din  out  8  byte to transmit; stable from START through DONE.
- m_done  in  1  master completion pulse.
- m_dout  in  8  master received byte; valid while m_done is high.
- cs_n  out  4  active-low chip select; requester i targets slave i.

The clock is one clock, `clk`. Reset is `reset`: synchronous and active-low. This polarity and synchronicity are fixed.

## Operation
- FSM states: IDLE, ARB, START, WAIT, DONE. All outputs are registered.
- IDLE: if any req bit is high, go to ARB. Otherwise stay.
- ARB:
  - Select the winner by round robin: search from `ptr` upward, wrapping 3→0.
  - Latch the winner index into `sel`.
  - Latch req_data[sel] into m_din.
  - Set ptr = sel+1 mod 4.
  - Go to START.
- START: m_start=1 for exactly this cycle. cs_n[sel]=0. Clear the watchdog counter. Go to WAIT.
- WAIT: cs_n[sel] stays 0. The 8-bit counter increments each cycle.
  - If m_done=1: capture m_dout into rsp_data, set timeout_err=0, go to DONE.
  - Else if counter == TIMEOUT-1: set rsp_data=8'h00, set timeout_err=1, go to DONE.
- DONE: ack[sel]=1 for one cycle. All cs_n=1. Go to IDLE.
- Boundary rules:
  - m_done and the watchdog expiring in the same cycle: m_done wins, timeout_err=0.
  - m_done outside WAIT is ignored. This includes m_done in the START cycle.
  - req[sel] dropped after ARB: the transaction still completes and ack[sel] still pulses. req changes after ARB never alter m_din.
  - Requester still holding req after its ack is re-arbitrated normally. Round robin serves the other pending requesters first.
  - At most one ack bit and at most one cs_n bit are active at any time.
  - Reset mid-transaction: on the next edge, return to IDLE, restore all reset values, and release cs_n immediately. No ack is issued for the aborted transaction.
- Reset values:
  - outputs: ack=0, rsp_data=0, timeout_err=0, m_start=0, m_din=0, cs_n=4'hF;
  - internal: ptr=0, sel=0, counter=0.

## Timing
- req sampled high in IDLE at edge k:
  - ARB during cycle k+1;
  - m_start and cs_n low during cycle k+2;
  - WAIT from cycle k+3.
- m_done sampled high at edge t in WAIT: ack, rsp_data and cs_n release during cycle t+1. IDLE at t+2.
- Minimum request-to-ack latency: 4 cycles plus the master's duration.
- Back-to-back transactions: next ARB no earlier than 2 cycles after the DONE cycle (DONE→IDLE→ARB).
- Timeout: ack arrives TIMEOUT+1 cycles after the START cycle.

## Configuration
- SPI_ARB_FIXED_PRIO_EN defined:
  - ARB uses fixed priority, lowest index wins (requester 0 highest);
  - ptr is unused.
- Undefined (default): round robin as described above.
- All other behaviour is identical in both builds.

## Test plan
- Single request: reset, then req=4'b0100 with req_data[23:16]=8'hA5. Master returns m_dout=8'h3C after 16 cycles. Required: m_din=8'hA5, m_start one pulse, cs_n=4'b1011 through WAIT, ack=4'b0100 with rsp_data=8'h3C, timeout_err=0.
- Fairness: req=4'b1111 held, each requester re-requesting after its ack. Required: grant order 0,1,2,3,0. With SPI_ARB_FIXED_PRIO_EN, requester 0 is granted every time.
- Timeout: TIMEOUT=40, m_done never asserted. Required: ack 41 cycles after START, timeout_err=1, rsp_data=8'h00, cs_n=4'hF in the ack cycle.
- Collision: m_done=1 in the same cycle the counter reaches 39. Required: timeout_err=0 and rsp_data=m_dout.
- Request withdrawal: req[1] dropped in the START cycle. Required: transaction completes, ack=4'b0010.
- Mid-operation reset: reset=0 during WAIT. Required: next edge cs_n=4'hF, ack=0, state IDLE. After release, req=4'b1000 is granted and the next round-robin search starts from requester 0.
